// File: rtl/lcd_text_buffer.sv
// Character-cell text buffer for the 800x480 LCD character path.
// Holds one 6-bit character code per 8x8 cell, accepts PUT/SETCUR/CLEAR/NEWLINE
// commands over a valid/ready handshake and, for every pixel coordinate from the
// sync generator, returns that cell's code two clocks later, together with the
// matching in-cell row/column and DEN.
module lcd_text_buffer #(
  parameter int          H_CELLS    = 100,
  parameter int          V_CELLS    = 60,
  parameter logic [5:0]  BLANK_CHAR = 6'o00
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [10:0] Columna,
  input  logic [9:0]  Fila,
  input  logic        DEN,
  input  logic        wr_valid,
  input  logic [1:0]  wr_cmd,
  input  logic [12:0] wr_data,
  output logic        wr_ready,
  output logic        busy,
  output logic [5:0]  Caracter,
  output logic [2:0]  Fila_char,
  output logic [2:0]  Col_char,
  output logic        den_out
);

  localparam int          CELLS     = H_CELLS * V_CELLS;
  localparam logic [12:0] LAST_ADDR = 13'(CELLS - 1);
  localparam logic [6:0]  LAST_X    = 7'(H_CELLS - 1);
  localparam logic [5:0]  LAST_Y    = 6'(V_CELLS - 1);

  localparam logic [1:0] CMD_PUT     = 2'b00;
  localparam logic [1:0] CMD_SETCUR  = 2'b01;
  localparam logic [1:0] CMD_CLEAR   = 2'b10;
  localparam logic [1:0] CMD_NEWLINE = 2'b11;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  // Character storage; contents are not reset, the reset-time clear blanks them.
  logic [5:0] mem_q [CELLS];

  // ---------------- display read pipeline ----------------
  logic [12:0] rd_addr_d;
  logic        oor_d;

  logic [12:0] rd_addr_p0;
  logic        oor_p0;
  logic [2:0]  col_p0;
  logic [2:0]  fila_p0;
  logic        den_p0;

  logic [5:0]  car_p1;
  logic [2:0]  col_p1;
  logic [2:0]  fila_p1;
  logic        den_p1;

  // Cell address of the incoming pixel and its out-of-panel flag.
  always_comb begin
    rd_addr_d = 13'({6'd0, Fila[9:3]}) * 13'(H_CELLS) + 13'({5'd0, Columna[10:3]});
    oor_d     = (Columna >= 11'(8 * H_CELLS)) || (Fila >= 10'(8 * V_CELLS));
  end

  // Stage 1: register the cell address, range flag and in-cell position.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_addr_p0 <= '0;
      oor_p0     <= 1'b0;
      col_p0     <= '0;
      fila_p0    <= '0;
      den_p0     <= 1'b0;
    end else begin
      rd_addr_p0 <= rd_addr_d;
      oor_p0     <= oor_d;
      col_p0     <= Columna[2:0];
      fila_p0    <= Fila[2:0];
      den_p0     <= DEN;
    end
  end

  // Stage 2: RAM read (old data on a same-cycle write), blanked outside the panel.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      car_p1  <= BLANK_CHAR;
      col_p1  <= '0;
      fila_p1 <= '0;
      den_p1  <= 1'b0;
    end else begin
      car_p1  <= oor_p0 ? BLANK_CHAR : mem_q[rd_addr_p0];
      col_p1  <= col_p0;
      fila_p1 <= fila_p0;
      den_p1  <= den_p0;
    end
  end

  assign Caracter  = car_p1;
  assign Col_char  = col_p1;
  assign Fila_char = fila_p1;
  assign den_out   = den_p1;

  // ---------------- command FSM ----------------
  state_t      state_q, state_d;
  logic [12:0] clr_addr_q, clr_addr_d;
  logic [6:0]  cur_x_q, cur_x_d;
  logic [5:0]  cur_y_q, cur_y_d;

  logic        we;
  logic [12:0] wa;
  logic [5:0]  wd;
  logic [12:0] cur_addr;
  logic [5:0]  y_next;

  assign cur_addr = 13'(cur_y_q) * 13'(H_CELLS) + 13'(cur_x_q);
  assign y_next   = (cur_y_q == LAST_Y) ? 6'd0 : cur_y_q + 6'd1;

  // Control registers; reset lands in CLEAR so the screen is blanked from address 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
    end
  end

  // Next-state, cursor update and write-port control.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    we         = 1'b0;
    wa         = cur_addr;
    wd         = wr_data[5:0];
    case (state_q)
      S_IDLE: begin
        if (wr_valid) begin
          case (wr_cmd)
            CMD_PUT: begin
              we = 1'b1;
              if (cur_x_q == LAST_X) begin
                cur_x_d = '0;
                cur_y_d = y_next;
              end else begin
                cur_x_d = cur_x_q + 7'd1;
              end
            end
            CMD_SETCUR: begin
              if ((wr_data[6:0] < 7'(H_CELLS)) && (wr_data[12:7] < 6'(V_CELLS))) begin
                cur_x_d = wr_data[6:0];
                cur_y_d = wr_data[12:7];
              end
            end
            CMD_CLEAR: begin
              state_d    = S_CLEAR;
              clr_addr_d = '0;
            end
            default: begin
              cur_x_d = '0;
              cur_y_d = y_next;
            end
          endcase
        end
      end
      default: begin
        we = 1'b1;
        wa = clr_addr_q;
        wd = BLANK_CHAR;
        if (clr_addr_q == LAST_ADDR) begin
          state_d = S_IDLE;
          cur_x_d = '0;
          cur_y_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 13'd1;
        end
      end
    endcase
  end

  // Single write port into the character RAM.
  always_ff @(posedge CLK) begin
    if (we) mem_q[wa] <= wd;
  end

  assign wr_ready = (state_q == S_IDLE);
  assign busy     = (state_q == S_CLEAR);

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Randomized bench for lcd_text_buffer against a cell-array reference model.
module tb_lcd_text_buffer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [10:0] Columna;
  logic [9:0]  Fila;
  logic        DEN;
  logic        wr_valid;
  logic [1:0]  wr_cmd;
  logic [12:0] wr_data;
  logic        wr_ready;
  logic        busy;
  logic [5:0]  Caracter;
  logic [2:0]  Fila_char;
  logic [2:0]  Col_char;
  logic        den_out;

  always #5 CLK = ~CLK;

  lcd_text_buffer dut (
    .CLK       (CLK),
    .RST       (RST),
    .Columna   (Columna),
    .Fila      (Fila),
    .DEN       (DEN),
    .wr_valid  (wr_valid),
    .wr_cmd    (wr_cmd),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .busy      (busy),
    .Caracter  (Caracter),
    .Fila_char (Fila_char),
    .Col_char  (Col_char),
    .den_out   (den_out)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: screen as a flat cell array plus the cursor.
  int mem_m [6000];
  int cx_m = 0;
  int cy_m = 0;

  typedef struct {
    int          c;
    int          f;
    logic [12:0] e;
  } px_t;
  px_t pq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [5:0] ref_char(input int c, input int f);
    if (c >= 800 || f >= 480) return 6'd0;
    return 6'(mem_m[(f / 8) * 100 + c / 8]);
  endfunction

  task automatic compare_front();
    px_t q;
    q = pq.pop_front();
    check($sformatf("pix c=%0d f=%0d", q.c, q.f),
          {19'd0, Caracter, Fila_char, Col_char, den_out}, {19'd0, q.e});
  endtask

  // Drive one pixel; compares the pixel driven one call earlier (2-cycle latency).
  task automatic drive_px(input int c, input int f, input logic d, input int force_car);
    px_t p;
    logic [5:0] ch;
    Columna = 11'(c);
    Fila    = 10'(f);
    DEN     = d;
    ch  = (force_car < 0) ? ref_char(c, f) : 6'(force_car);
    p.c = c;
    p.f = f;
    p.e = {ch, 3'(f), 3'(c), d};
    pq.push_back(p);
    tick();
    if (pq.size() >= 2) compare_front();
  endtask

  task automatic flush();
    tick();
    while (pq.size() > 0) compare_front();
  endtask

  task automatic scan_frame();
    int c;
    int f;
    for (int idx = 0; idx < 6000; idx++) begin
      c = (idx % 100) * 8 + int'($urandom % 8);
      f = (idx / 100) * 8 + int'($urandom % 8);
      if (idx % 97 == 0) c = 800 + int'($urandom % 1248);
      drive_px(c, f, 1'($urandom), -1);
    end
    flush();
  endtask

  task automatic model_clear();
    for (int i = 0; i < 6000; i++) mem_m[i] = 0;
    cx_m = 0;
    cy_m = 0;
  endtask

  task automatic wait_ready(input string tag, input int expect_n);
    int n = 0;
    while (!wr_ready && n < 7000) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(expect_n));
  endtask

  // Issue one command through the handshake and update the model.
  task automatic cmd(input logic [1:0] c, input logic [12:0] d, input bit wait_clr);
    int n = 0;
    while (!wr_ready && n < 20000) begin
      tick();
      n++;
    end
    check("cmd_ready", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1;
    wr_cmd   = c;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    wr_cmd   = 2'($urandom);
    wr_data  = 13'($urandom);
    case (c)
      2'b00: begin
        mem_m[cy_m * 100 + cx_m] = int'(d[5:0]);
        cx_m++;
        if (cx_m == 100) begin
          cx_m = 0;
          cy_m = (cy_m == 59) ? 0 : cy_m + 1;
        end
      end
      2'b01: begin
        if (int'(d[6:0]) < 100 && int'(d[12:7]) < 60) begin
          cx_m = int'(d[6:0]);
          cy_m = int'(d[12:7]);
        end
      end
      2'b10: begin
        model_clear();
        check("clear_busy", 32'(busy), 32'd1);
        check("clear_ready_low", 32'(wr_ready), 32'd0);
        if (wait_clr) wait_ready("clear_len", 6000);
      end
      default: begin
        cx_m = 0;
        cy_m = (cy_m == 59) ? 0 : cy_m + 1;
      end
    endcase
  endtask

  initial begin
    int r;
    RST      = 1'b0;
    Columna  = '0;
    Fila     = '0;
    DEN      = 1'b0;
    wr_valid = 1'b0;
    wr_cmd   = '0;
    wr_data  = '0;
    model_clear();

    // Reset values
    #2 RST = 1'b1;
    #1;
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_caracter", 32'(Caracter), 32'd0);
    check("rst_fila_char", 32'(Fila_char), 32'd0);
    check("rst_col_char", 32'(Col_char), 32'd0);
    check("rst_den_out", 32'(den_out), 32'd0);
    tick();
    tick();
    check("rst_hold_ready", 32'(wr_ready), 32'd0);
    RST = 1'b0;
    wait_ready("rst_clear_len", 6000);
    check("idle_busy", 32'(busy), 32'd0);

    // Blank screen after reset
    scan_frame();

    // Single PUT at the home cell
    cmd(2'b00, 13'd1, 1'b0);
    for (int f = 0; f < 16; f++)
      for (int c = 0; c < 16; c++)
        drive_px(c, f, 1'((c + f) % 2), (c < 8 && f < 8) ? 1 : 0);
    flush();

    // Whole-screen wrap, NEWLINE wrap
    cmd(2'b01, {6'd59, 7'd99}, 1'b0);
    cmd(2'b00, 13'd5, 1'b0);
    cmd(2'b00, 13'd6, 1'b0);
    cmd(2'b00, 13'd7, 1'b0);
    drive_px(792, 472, 1'b1, 5);
    drive_px(0, 0, 1'b1, 6);
    drive_px(15, 7, 1'b1, 7);
    flush();
    cmd(2'b01, {6'd59, 7'd5}, 1'b0);
    cmd(2'b11, 13'd0, 1'b0);
    cmd(2'b00, 13'd9, 1'b0);
    drive_px(0, 0, 1'b1, 9);
    flush();

    // Invalid SETCUR leaves the cursor at (1,0)
    cmd(2'b01, {6'd3, 7'd100}, 1'b0);
    cmd(2'b01, {6'd60, 7'd3}, 1'b0);
    cmd(2'b00, 13'd11, 1'b0);
    drive_px(8, 0, 1'b1, 11);
    drive_px(24, 24, 1'b1, 0);
    drive_px(0, 480, 1'b1, 0);
    flush();

    // Out-of-range coordinates and panel edges
    drive_px(850, 3, 1'b1, 0);
    drive_px(3, 500, 1'b0, 0);
    drive_px(850, 3, 1'b0, 0);
    drive_px(2047, 1023, 1'b1, 0);
    drive_px(800, 0, 1'b1, 0);
    drive_px(799, 479, 1'b1, 5);
    drive_px(0, 0, 1'b1, 9);
    flush();

    // Randomized command traffic, then a full scan against the model
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom % 10);
      if (r < 6)       cmd(2'b00, 13'($urandom), 1'b0);
      else if (r < 8)  cmd(2'b01, {6'($urandom % 64), 7'($urandom % 110)}, 1'b0);
      else if (r == 8) cmd(2'b11, 13'($urandom), 1'b0);
      else begin
        wr_cmd  = 2'($urandom);
        wr_data = 13'($urandom);
        for (int k = 0; k < int'($urandom % 4); k++) tick();
      end
    end
    scan_frame();

    // Commanded CLEAR: 6000 busy cycles, then blank screen
    cmd(2'b10, 13'd0, 1'b1);
    check("after_clear_busy", 32'(busy), 32'd0);
    scan_frame();

    // Reset in the middle of a clear restarts it and homes the cursor
    cmd(2'b01, {6'd10, 7'd10}, 1'b0);
    cmd(2'b00, 13'd3, 1'b0);
    cmd(2'b10, 13'd0, 1'b0);
    for (int k = 0; k < 2999; k++) tick();
    check("midclear_busy", 32'(busy), 32'd1);
    RST = 1'b1;
    #1;
    check("midclear_rst_ready", 32'(wr_ready), 32'd0);
    tick();
    RST = 1'b0;
    wait_ready("midclear_len", 6000);
    cmd(2'b00, 13'd7, 1'b0);
    drive_px(0, 0, 1'b1, 7);
    drive_px(80, 80, 1'b1, 0);
    drive_px(8, 0, 1'b1, 0);
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
